// File: rtl/io_write_ports.sv
// Memory-mapped output ports: each port holds one processor-written word until the external
// consumer drains it. Writes to a full, undrained port are rejected and flagged.
module io_write_ports #(
  parameter int unsigned WORD_WIDTH      = 36,
  parameter int unsigned ADDR_WIDTH      = 10,
  parameter int unsigned PORT_COUNT      = 4,
  parameter int unsigned PORT_BASE_ADDR  = 0,
  parameter int unsigned PORT_ADDR_WIDTH = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wren,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [WORD_WIDTH-1:0]            data_in,
  output logic [PORT_COUNT-1:0]            port_EF,
  output logic [PORT_COUNT*WORD_WIDTH-1:0] port_data_out,
  output logic [PORT_COUNT-1:0]            port_valid,
  input  logic [PORT_COUNT-1:0]            port_ready,
  output logic                             write_dropped
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e                st_q   [PORT_COUNT];
  state_e                st_d   [PORT_COUNT];
  logic [WORD_WIDTH-1:0] data_q [PORT_COUNT];
  logic [WORD_WIDTH-1:0] data_d [PORT_COUNT];
  logic                  drop_q, drop_d;
  logic [PORT_COUNT-1:0] sel;
  logic [31:0]           addr_ext;
  logic [31:0]           offset;
  logic                  in_range;

  // Hit decode: the index is the truncated offset from the base, qualified by the range check.
  always_comb begin
    addr_ext = 32'(addr);
    offset   = addr_ext - PORT_BASE_ADDR;
    in_range = (addr_ext >= PORT_BASE_ADDR) && (addr_ext < PORT_BASE_ADDR + PORT_COUNT);
    sel      = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      sel[i] = wren && in_range &&
               (offset[PORT_ADDR_WIDTH-1:0] == PORT_ADDR_WIDTH'(i));
    end
  end

  always_comb begin
    drop_d = 1'b0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      st_d[i]   = st_q[i];
      data_d[i] = data_q[i];
      unique case (st_q[i])
        StEmpty: begin
          if (sel[i]) begin
            data_d[i] = data_in;
            st_d[i]   = StFull;
          end
        end
        StFull: begin
          if (port_ready[i]) begin
            // Drain and refill in the same cycle keeps the port full with the new word.
            if (sel[i]) begin
              data_d[i] = data_in;
            end else begin
              st_d[i] = StEmpty;
            end
          end else if (sel[i]) begin
            drop_d = 1'b1;
          end
        end
        default: st_d[i] = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= 1'b0;
      for (int i = 0; i < PORT_COUNT; i++) begin
        st_q[i]   <= StEmpty;
        data_q[i] <= '0;
      end
    end else begin
      drop_q <= drop_d;
      for (int i = 0; i < PORT_COUNT; i++) begin
        st_q[i]   <= st_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    port_data_out = '0;
    port_EF       = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      port_EF[i]                                 = (st_q[i] == StFull);
      port_data_out[i*WORD_WIDTH +: WORD_WIDTH] = data_q[i];
    end
  end

  assign port_valid    = port_EF;
  assign write_dropped = drop_q;

endmodule

// File: tb/tb_io_write_ports.sv
// Directed bench for io_write_ports: the driver queues hand-computed expectations per cycle,
// and a monitor checks each one just after the clock edge that should produce it.
module tb_io_write_ports;

  localparam int unsigned WW = 36;
  localparam int unsigned AW = 10;
  localparam int unsigned PC = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               wren;
  logic [AW-1:0]      addr;
  logic [WW-1:0]      data_in;
  logic [PC-1:0]      port_EF;
  logic [PC*WW-1:0]   port_data_out;
  logic [PC-1:0]      port_valid;
  logic [PC-1:0]      port_ready;
  logic               write_dropped;

  io_write_ports #(
    .WORD_WIDTH     (WW),
    .ADDR_WIDTH     (AW),
    .PORT_COUNT     (PC),
    .PORT_BASE_ADDR (8),
    .PORT_ADDR_WIDTH(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .addr         (addr),
    .data_in      (data_in),
    .port_EF      (port_EF),
    .port_data_out(port_data_out),
    .port_valid   (port_valid),
    .port_ready   (port_ready),
    .write_dropped(write_dropped)
  );

  always #5 clock = ~clock;

  typedef struct {
    string          name;
    logic [PC-1:0]  ef;
    logic           drop;
    logic [PC*WW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (port_EF !== e.ef || port_valid !== e.ef) begin
        n_bad++;
        $display("FAIL %s ef: got EF=%b valid=%b want %b", e.name, port_EF, port_valid, e.ef);
      end
      n_cmp++;
      if (write_dropped !== e.drop) begin
        n_bad++;
        $display("FAIL %s drop: got %b want %b", e.name, write_dropped, e.drop);
      end
      n_cmp++;
      if (port_data_out !== e.data) begin
        n_bad++;
        $display("FAIL %s data: got %h want %h", e.name, port_data_out, e.data);
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic we, input int a,
                      input logic [WW-1:0] d, input logic [PC-1:0] rdy,
                      input logic [PC-1:0] ef, input logic drop,
                      input logic [WW-1:0] d3, input logic [WW-1:0] d2,
                      input logic [WW-1:0] d1, input logic [WW-1:0] d0);
    exp_t e;
    @(negedge clock);
    reset      = rst;
    wren       = we;
    addr       = AW'(a);
    data_in    = d;
    port_ready = rdy;
    e.name = name;
    e.ef   = ef;
    e.drop = drop;
    e.data = {d3, d2, d1, d0};
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; wren = 1'b0; addr = '0; data_in = '0; port_ready = '0;
    //     name          rst we  addr data      ready    ef       drp d3     d2     d1     d0
    step("reset",        1, 0,  0,  36'h0,   4'b0000, 4'b0000, 0, 36'h0, 36'h0, 36'h0, 36'h0);
    step("idle",         0, 0,  0,  36'h0,   4'b0000, 4'b0000, 0, 36'h0, 36'h0, 36'h0, 36'h0);
    step("wr_p2",        0, 1, 10,  36'h5A,  4'b0000, 4'b0100, 0, 36'h0, 36'h5A, 36'h0, 36'h0);
    step("drain_p2",     0, 0,  0,  36'h0,   4'b0100, 4'b0000, 0, 36'h0, 36'h5A, 36'h0, 36'h0);
    step("rdy_empty",    0, 0,  0,  36'h0,   4'b1111, 4'b0000, 0, 36'h0, 36'h5A, 36'h0, 36'h0);
    step("wr_p0",        0, 1,  8,  36'h11,  4'b0000, 4'b0001, 0, 36'h0, 36'h5A, 36'h0, 36'h11);
    step("drop_p0",      0, 1,  8,  36'h22,  4'b0000, 4'b0001, 1, 36'h0, 36'h5A, 36'h0, 36'h11);
    step("drop_end",     0, 0,  0,  36'h0,   4'b0000, 4'b0001, 0, 36'h0, 36'h5A, 36'h0, 36'h11);
    step("wr_p1",        0, 1,  9,  36'h33,  4'b0000, 4'b0011, 0, 36'h0, 36'h5A, 36'h33, 36'h11);
    step("drain_wr_p1",  0, 1,  9,  36'h44,  4'b0010, 4'b0011, 0, 36'h0, 36'h5A, 36'h44, 36'h11);
    step("drain_all",    0, 0,  0,  36'h0,   4'b1111, 4'b0000, 0, 36'h0, 36'h5A, 36'h44, 36'h11);
    step("addr7",        0, 1,  7,  36'h77,  4'b0000, 4'b0000, 0, 36'h0, 36'h5A, 36'h44, 36'h11);
    step("addr12",       0, 1, 12,  36'hCC,  4'b0000, 4'b0000, 0, 36'h0, 36'h5A, 36'h44, 36'h11);
    step("addr8",        0, 1,  8,  36'h88,  4'b0000, 4'b0001, 0, 36'h0, 36'h5A, 36'h44, 36'h88);
    step("addr11",       0, 1, 11,  36'hBB,  4'b0000, 4'b1001, 0, 36'hBB, 36'h5A, 36'h44, 36'h88);
    step("drain_p3",     0, 0,  0,  36'h0,   4'b1000, 4'b0001, 0, 36'hBB, 36'h5A, 36'h44, 36'h88);
    step("wr_p1b",       0, 1,  9,  36'h99,  4'b0000, 4'b0011, 0, 36'hBB, 36'h5A, 36'h99, 36'h88);
    step("indep",        0, 1, 11,  36'hDD,  4'b0011, 4'b1000, 0, 36'hDD, 36'h5A, 36'h99, 36'h88);
    step("fill_p0",      0, 1,  8,  36'hA0,  4'b0000, 4'b1001, 0, 36'hDD, 36'h5A, 36'h99, 36'hA0);
    step("fill_p1",      0, 1,  9,  36'hA1,  4'b0000, 4'b1011, 0, 36'hDD, 36'h5A, 36'hA1, 36'hA0);
    step("fill_p2",      0, 1, 10,  36'hA2,  4'b0000, 4'b1111, 0, 36'hDD, 36'hA2, 36'hA1, 36'hA0);
    step("reset_mid",    1, 1,  9,  36'hEE,  4'b0000, 4'b0000, 0, 36'h0, 36'h0, 36'h0, 36'h0);
    step("post_reset",   0, 1, 10,  36'h9_8765_4321, 4'b1111, 4'b0100, 0,
         36'h0, 36'h9_8765_4321, 36'h0, 36'h0);
    step("quiet",        0, 0,  0,  36'h0,   4'b0000, 4'b0100, 0,
         36'h0, 36'h9_8765_4321, 36'h0, 36'h0);
    @(negedge clock);
    wren = 1'b0;
    port_ready = '0;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_write_ports.md
IO_WRITE_PORTS -- requirements
Module: io_write_ports

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 36, bits per port word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, width of the processor write address.
REQ-003 SHALL have parameter PORT_COUNT, default 4, number of output ports (1..2^PORT_ADDR_WIDTH).
REQ-004 SHALL have parameter PORT_BASE_ADDR, default 0, address of port 0.
REQ-005 SHALL have parameter PORT_ADDR_WIDTH, default 2, width of the port index.
REQ-006 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port wren, input, 1, processor write strobe.
REQ-009 SHALL have port addr, input, ADDR_WIDTH, processor write address.
REQ-010 SHALL have port data_in, input, WORD_WIDTH, processor write data.
REQ-011 SHALL have port port_EF, output, PORT_COUNT, per-port Empty/Full bit (1 = full, 0 = empty) for the processor-side I/O check.
REQ-012 SHALL have port port_data_out, output, PORT_COUNT*WORD_WIDTH, held word per port; port i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-013 SHALL have port port_valid, output, PORT_COUNT, external-side valid; identical to port_EF.
REQ-014 SHALL have port port_ready, input, PORT_COUNT, external-side consumer ready.
REQ-015 SHALL have port write_dropped, output, 1, one-cycle pulse when a write is rejected.

Function
REQ-016 SHALL decode a hit when PORT_BASE_ADDR <= addr < PORT_BASE_ADDR+PORT_COUNT; port index = (addr - PORT_BASE_ADDR), truncated to PORT_ADDR_WIDTH.
REQ-017 SHALL ignore wren when there is no hit: no state change, no write_dropped.
REQ-018 SHALL give each port a two-state machine, EMPTY (EF=0) and FULL (EF=1).
REQ-019 SHALL, in EMPTY, on a hit write to that port: capture data_in and move to FULL; port_EF, port_valid and port_data_out update the next cycle (1-cycle latency).
REQ-020 SHALL, in FULL, when port_ready=1: complete the drain handshake and move to EMPTY next cycle, unless REQ-021 applies.
REQ-021 SHALL, in FULL, with port_ready=1 and a hit write to the same port in the same cycle: capture the new word and stay FULL.
REQ-022 SHALL, in FULL, with port_ready=0 and a hit write to that port: reject the write, keep the held word and FULL state, and pulse write_dropped=1 on the next cycle.
REQ-023 SHALL keep port_data_out stable while in FULL unless REQ-021 applies; contents in EMPTY are don't-care but SHALL not change except on a capture.
REQ-024 SHALL run ports independently; a write to port i and drains on any other ports in the same cycle SHALL all take effect.
REQ-025 SHALL ignore port_ready while a port is EMPTY.
REQ-026 SHALL not change any output combinationally from its inputs; all outputs are registered.

Reset
REQ-027 SHALL, while reset=1 on a clock edge, set all ports to EMPTY: port_EF=0, port_valid=0, port_data_out=0, write_dropped=0.
REQ-028 SHALL give reset priority over a concurrent write or drain; held words asserted before reset SHALL be discarded.
REQ-029 SHALL accept writes on the first edge after reset deasserts.

Verification
REQ-030 SHALL cover basic write: BASE=8, COUNT=4; reset, then wren=1, addr=10, data=0x5A at cycle N -> port_EF=4'b0100, port 2 data 0x5A at N+1; port_ready[2]=1 at N+1 -> port_EF=0 at N+2.
REQ-031 SHALL cover dropped write: port 0 FULL holding 0x11, port_ready=0, write 0x22 to addr 8 -> write_dropped=1 for one cycle, port 0 still holds 0x11, EF stays 1.
REQ-032 SHALL cover simultaneous drain and write: port 1 FULL holding 0x33, port_ready[1]=1 and write 0x44 to addr 9 in the same cycle -> EF[1]=1 next cycle, data 0x44, no drop.
REQ-033 SHALL cover address boundaries: writes to addr 7 and addr 12 -> no EF change, no drop; writes to addr 8 and addr 11 -> EF bits 0 and 3 set.
REQ-034 SHALL cover reset mid-operation: all four ports FULL, assert reset with a concurrent write -> next cycle all EF=0, all data=0, write_dropped=0.
REQ-035 SHALL cover independence: write port 3 while draining ports 0 and 1 in the same cycle -> next cycle EF=4'b1000, assuming ports 0, 1 and 3 were {FULL, FULL, EMPTY} before.
